sodor_mem_arbiter: RTL and testbench

Shares one single-ported synchronous scratchpad between the Sodor core's instruction-fetch port (imem, read-only) and data port (dmem, read/write).
- Grants at most one request per cycle; dmem has priority, with an imem anti-starvation override.
- Routes the one-cycle-latency read data back to the owner.
- Flags out-of-range addresses.
- Sits between the core and the memory array inside the internal tile.

---
 rtl/sodor_mem_pkg.sv | 23 ++
 rtl/sodor_mem_prio_sel.sv | 49 ++++
 rtl/sodor_mem_arbiter.sv | 105 ++++++++++
 tb/tb_sodor_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sodor_mem_pkg.sv
// Shared types and helpers for the Sodor scratchpad arbiter.
// Defines the response-owner encoding and the address range check.
package sodor_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IMEM = 2'd1,
      OWN_DMEM = 2'd2
   } owner_e;

   localparam logic [31:0] SODOR_BASE_ADDR    = 32'h8000_0000;
   localparam int          SODOR_DEPTH_WORDS  = 4096;
   localparam int          SODOR_STARVE_LIMIT = 4;
   localparam int          CNT_W              = 4;

   // Widened to 64 bits so base + span cannot wrap at the top of the address space.
   function automatic logic in_range(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] span);
      return (addr >= base) && (addr < base + span);
   endfunction

endpackage

// File: rtl/sodor_mem_prio_sel.sv
// Grant selection between fetch and data ports: dmem wins by default,
// imem is forced through once it has lost STARVE_LIMIT consecutive cycles.
module sodor_mem_prio_sel
   import sodor_mem_pkg::*;
#(
   parameter int STARVE_LIMIT = SODOR_STARVE_LIMIT
)
(
   input  logic clock,
   input  logic reset,
   input  logic imem_valid,
   input  logic dmem_valid,
   output logic imem_gnt,
   output logic dmem_gnt
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_reg;
   logic [CNT_W-1:0] starve_cnt_next;

   always_comb begin
      imem_gnt        = 1'b0;
      dmem_gnt        = 1'b0;
      starve_cnt_next = starve_cnt_reg;
      // Grants are held off while reset is asserted so no access leaks out.
      if (!reset) begin
         if (imem_valid && (!dmem_valid || starve_cnt_reg == LIMIT)) begin
            imem_gnt = 1'b1;
         end else if (dmem_valid) begin
            dmem_gnt = 1'b1;
         end
      end
      if (!imem_valid || imem_gnt) begin
         starve_cnt_next = '0;
      end else if (starve_cnt_reg != LIMIT) begin
         starve_cnt_next = starve_cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
      end
   end

endmodule

// File: rtl/sodor_mem_arbiter.sv
// Single-ported scratchpad arbiter for the Sodor tile: one grant per cycle,
// range checking, and routing of the one-cycle-latency response to its owner.
module sodor_mem_arbiter
   import sodor_mem_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(SODOR_BASE_ADDR),
   parameter int                DEPTH_WORDS  = SODOR_DEPTH_WORDS,
   parameter int                STARVE_LIMIT = SODOR_STARVE_LIMIT,
   localparam int               MASK_W       = DATA_W / 8,
   localparam int               IDX_W        = $clog2(DEPTH_WORDS)
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              imem_req_valid,
   output logic              imem_req_ready,
   input  logic [ADDR_W-1:0] imem_req_addr,
   output logic              imem_resp_valid,
   output logic [DATA_W-1:0] imem_resp_data,
   output logic              imem_resp_err,
   input  logic              dmem_req_valid,
   output logic              dmem_req_ready,
   input  logic [ADDR_W-1:0] dmem_req_addr,
   input  logic              dmem_req_wen,
   input  logic [DATA_W-1:0] dmem_req_wdata,
   input  logic [MASK_W-1:0] dmem_req_wmask,
   output logic              dmem_resp_valid,
   output logic [DATA_W-1:0] dmem_resp_data,
   output logic              dmem_resp_err,
   output logic              mem_en,
   output logic              mem_wen,
   output logic [IDX_W-1:0]  mem_idx,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) * 64'd4;

   logic              imem_gnt;
   logic              dmem_gnt;
   logic              any_gnt;
   logic              sel_in_range;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   owner_e            owner_reg;
   owner_e            owner_next;
   logic              err_reg;
   logic              wen_reg;

   sodor_mem_prio_sel #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio_sel (
      .clock      (clock),
      .reset      (reset),
      .imem_valid (imem_req_valid),
      .dmem_valid (dmem_req_valid),
      .imem_gnt   (imem_gnt),
      .dmem_gnt   (dmem_gnt)
   );

   assign imem_req_ready = imem_gnt;
   assign dmem_req_ready = dmem_gnt;

   always_comb begin
      any_gnt      = imem_gnt | dmem_gnt;
      sel_addr     = imem_gnt ? imem_req_addr : dmem_req_addr;
      sel_in_range = in_range(64'(sel_addr), 64'(BASE_ADDR), SPAN_BYTES);
      sel_write    = dmem_gnt & dmem_req_wen;
      // Out-of-range requests never touch the array but still get a response.
      mem_en       = any_gnt & sel_in_range;
      mem_wen      = mem_en & sel_write;
      mem_idx      = mem_en ? IDX_W'((sel_addr - BASE_ADDR) >> 2) : '0;
      mem_wdata    = mem_wen ? dmem_req_wdata : '0;
      mem_wmask    = mem_wen ? dmem_req_wmask : '0;
      owner_next   = imem_gnt ? OWN_IMEM : (dmem_gnt ? OWN_DMEM : OWN_NONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner_reg <= OWN_NONE;
         err_reg   <= 1'b0;
         wen_reg   <= 1'b0;
      end else begin
         owner_reg <= owner_next;
         err_reg   <= any_gnt & ~sel_in_range;
         wen_reg   <= sel_write;
      end
   end

   always_comb begin
      imem_resp_valid = (owner_reg == OWN_IMEM);
      dmem_resp_valid = (owner_reg == OWN_DMEM);
      imem_resp_err   = imem_resp_valid & err_reg;
      dmem_resp_err   = dmem_resp_valid & err_reg;
      imem_resp_data  = (imem_resp_valid && !err_reg) ? mem_rdata : '0;
      dmem_resp_data  = (dmem_resp_valid && !err_reg && !wen_reg) ? mem_rdata : '0;
   end

   ready_one_hot: assert property (@(posedge clock) disable iff (reset)
      !(imem_req_ready && dmem_req_ready));

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Randomized bench for sodor_mem_arbiter with a transaction-level reference
// model (grant rule, lost-cycle count, shadow memory, pending response).
module tb_sodor_mem_arbiter;

   localparam int          DEPTH = 4096;
   localparam int          IDX_W = 12;
   localparam int          LIMIT = 4;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam longint      SPAN  = 4 * DEPTH;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              imem_req_valid = 1'b0;
   logic              imem_req_ready;
   logic [31:0]       imem_req_addr = '0;
   logic              imem_resp_valid;
   logic [31:0]       imem_resp_data;
   logic              imem_resp_err;
   logic              dmem_req_valid = 1'b0;
   logic              dmem_req_ready;
   logic [31:0]       dmem_req_addr = '0;
   logic              dmem_req_wen = 1'b0;
   logic [31:0]       dmem_req_wdata = '0;
   logic [3:0]        dmem_req_wmask = '0;
   logic              dmem_resp_valid;
   logic [31:0]       dmem_resp_data;
   logic              dmem_resp_err;
   logic              mem_en;
   logic              mem_wen;
   logic [IDX_W-1:0]  mem_idx;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic [31:0]       mem_rdata = '0;

   logic [31:0] mem_arr [DEPTH];
   logic        init_req = 1'b0;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] ref_mem [DEPTH];
   int          lost      = 0;
   int          pend_port = 0;
   logic [31:0] pend_data = '0;
   logic        pend_err  = 1'b0;
   int          cyc       = 0;

   always #5 clock = ~clock;

   sodor_mem_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .BASE_ADDR    (BASE),
      .DEPTH_WORDS  (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_req_addr   (dmem_req_addr),
      .dmem_req_wen    (dmem_req_wen),
      .dmem_req_wdata  (dmem_req_wdata),
      .dmem_req_wmask  (dmem_req_wmask),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_resp_data  (dmem_resp_data),
      .dmem_resp_err   (dmem_resp_err),
      .mem_en          (mem_en),
      .mem_wen         (mem_wen),
      .mem_idx         (mem_idx),
      .mem_wdata       (mem_wdata),
      .mem_wmask       (mem_wmask),
      .mem_rdata       (mem_rdata)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 'h400) return 32'h1122_3344;
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // Scratchpad model with registered read.
   always @(posedge clock) begin
      if (init_req) begin
         for (int i = 0; i < DEPTH; i++) mem_arr[i] <= init_word(i);
      end else if (mem_en) begin
         if (mem_wen) begin
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b]) mem_arr[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem_arr[mem_idx];
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return BASE - 32'd4;
         1:       return BASE + 32'(SPAN);
         2:       return BASE + 32'(SPAN) - 32'd4 + 32'($urandom_range(0, 3));
         default: return BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      endcase
   endfunction

   // Called at posedge+1: checks the response due now, applies one request
   // set, checks grant and memory strobes, then advances one clock.
   task automatic step(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic dw, input logic [31:0] dwd,
                       input logic [3:0] dwm, output int obs);
      int          g;
      int          idx;
      longint      off;
      logic        inr;
      logic        wr;
      logic [31:0] addr;
      check_val("imem_resp_valid", imem_resp_valid, pend_port == 1);
      check_val("dmem_resp_valid", dmem_resp_valid, pend_port == 2);
      if (pend_port == 1) begin
         check_val("imem_resp_data", imem_resp_data, pend_data);
         check_val("imem_resp_err", imem_resp_err, pend_err);
      end
      if (pend_port == 2) begin
         check_val("dmem_resp_data", dmem_resp_data, pend_data);
         check_val("dmem_resp_err", dmem_resp_err, pend_err);
      end
      imem_req_valid = iv;
      imem_req_addr  = ia;
      dmem_req_valid = dv;
      dmem_req_addr  = da;
      dmem_req_wen   = dw;
      dmem_req_wdata = dwd;
      dmem_req_wmask = dwm;
      #1;
      if (iv && (!dv || lost >= LIMIT)) g = 1;
      else if (dv)                      g = 2;
      else                              g = 0;
      obs = imem_req_ready ? 1 : (dmem_req_ready ? 2 : 0);
      check_val("imem_req_ready", imem_req_ready, g == 1);
      check_val("dmem_req_ready", dmem_req_ready, g == 2);
      addr = (g == 1) ? ia : da;
      off  = longint'(addr) - longint'(BASE);
      inr  = (off >= 0) && (off < SPAN);
      idx  = inr ? int'(off / 4) : 0;
      wr   = (g == 2) && dw;
      check_val("mem_en", mem_en, (g != 0) && inr);
      check_val("mem_wen", mem_wen, (g != 0) && inr && wr);
      if (g != 0 && inr) check_val("mem_idx", mem_idx, idx);
      if (g != 0 && inr && wr) begin
         check_val("mem_wdata", mem_wdata, dwd);
         check_val("mem_wmask", mem_wmask, dwm);
      end
      pend_port = g;
      pend_err  = (g != 0) && !inr;
      pend_data = ((g != 0) && inr && !wr) ? ref_mem[idx] : 32'h0;
      if (g != 0 && inr && wr)
         for (int b = 0; b < 4; b++)
            if (dwm[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
      if (iv && g != 1) lost = (lost < LIMIT) ? lost + 1 : LIMIT;
      else              lost = 0;
      $display("cyc %0d: iv=%0b ia=%h dv=%0b da=%h wen=%0b -> grant %s", cyc, iv, ia, dv, da, dw,
               (g == 1) ? "imem" : ((g == 2) ? "dmem" : "none"));
      cyc++;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int obs;
      int pat [10];
      pat = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

      // Reset with both ports requesting: nothing may leak out.
      imem_req_valid = 1'b1;
      imem_req_addr  = BASE;
      dmem_req_valid = 1'b1;
      dmem_req_addr  = BASE;
      dmem_req_wen   = 1'b1;
      dmem_req_wdata = 32'hFFFF_FFFF;
      dmem_req_wmask = 4'hF;
      init_req       = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      #1;
      check_val("rst_imem_ready", imem_req_ready, 0);
      check_val("rst_dmem_ready", dmem_req_ready, 0);
      check_val("rst_mem_en", mem_en, 0);
      check_val("rst_mem_wen", mem_wen, 0);
      check_val("rst_mem_idx", mem_idx, 0);
      check_val("rst_mem_wdata", mem_wdata, 0);
      check_val("rst_mem_wmask", mem_wmask, 0);
      check_val("rst_imem_resp", {imem_resp_valid, imem_resp_err, imem_resp_data}, 0);
      check_val("rst_dmem_resp", {dmem_resp_valid, dmem_resp_err, dmem_resp_data}, 0);
      @(posedge clock);
      #1;
      init_req       = 1'b0;
      imem_req_valid = 1'b0;
      dmem_req_valid = 1'b0;
      dmem_req_wen   = 1'b0;
      #1 reset = 1'b0;
      @(posedge clock);
      #1;

      // Back-to-back fetches.
      step(1, BASE,         0, 0, 0, 0, 0, obs);
      step(1, BASE + 32'd4, 0, 0, 0, 0, 0, obs);
      step(1, BASE + 32'd8, 0, 0, 0, 0, 0, obs);
      step(0, 0, 0, 0, 0, 0, 0, obs);

      // Masked write then read-back of the same word.
      step(0, 0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, obs);
      check_val("wr_resp_data", dmem_resp_data, 0);
      step(0, 0, 1, 32'h8000_1000, 0, 0, 0, obs);
      check_val("rmw_read_data", dmem_resp_data, 32'h1122_BEEF);
      step(0, 0, 0, 0, 0, 0, 0, obs);

      // Both ports requesting continuously.
      for (int k = 0; k < 10; k++) begin
         step(1, BASE + 32'(4 * k), 1, BASE + 32'h100 + 32'(4 * k), 0, 0, 0, obs);
         check_val("starve_pattern", obs, pat[k]);
      end
      step(0, 0, 0, 0, 0, 0, 0, obs);

      // Out-of-range accesses on both sides of the window.
      step(0, 0, 1, 32'h7FFF_FFFC, 0, 0, 0, obs);
      check_val("oor_dmem_err", {dmem_resp_valid, dmem_resp_err, dmem_resp_data}, {2'b11, 32'h0});
      step(1, 32'h8000_4000, 0, 0, 0, 0, 0, obs);
      check_val("oor_imem_err", {imem_resp_valid, imem_resp_err, imem_resp_data}, {2'b11, 32'h0});
      step(0, 0, 1, 32'h8000_4000, 1, 32'hFFFF_FFFF, 4'hF, obs);
      step(0, 0, 1, 32'h8000_3FFC, 0, 0, 0, obs);
      step(0, 0, 0, 0, 0, 0, 0, obs);

      // Asynchronous reset in the middle of a granted fetch cycle.
      imem_req_valid = 1'b1;
      imem_req_addr  = BASE + 32'd8;
      dmem_req_valid = 1'b0;
      dmem_req_wen   = 1'b0;
      #1;
      check_val("pre_rst_ready", imem_req_ready, 1);
      #1 reset = 1'b1;
      #1;
      check_val("async_rst_ready", imem_req_ready, 0);
      check_val("async_rst_mem_en", mem_en, 0);
      check_val("async_rst_resp", {imem_resp_valid, dmem_resp_valid, imem_resp_data}, 0);
      @(posedge clock);
      #1;
      check_val("dropped_resp", {imem_resp_valid, dmem_resp_valid}, 0);
      imem_req_valid = 1'b0;
      #2 reset = 1'b0;
      pend_port = 0;
      lost      = 0;
      @(posedge clock);
      #1;
      step(1, BASE + 32'd12, 0, 0, 0, 0, 0, obs);
      step(0, 0, 0, 0, 0, 0, 0, obs);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0, rand_addr(),
              $urandom_range(0, 1) != 0, $urandom, 4'($urandom_range(0, 15)), obs);
      end
      step(0, 0, 0, 0, 0, 0, 0, obs);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
